// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a circular transmit FIFO.
// Frame format, baud divisor and FIFO depth are set by parameters.
module uart_tx_fifo #(
    parameter int DIV       = 4,
    parameter int DEPTH     = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  wr_data,
    input  logic        ovf_clr,
    output logic [31:0] status,
    output logic        uart_tx
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(DIV);
    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_n;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_n;
    logic [7:0]        shift;
    logic [7:0]        shift_n;
    logic              par_bit;
    logic              par_bit_n;
    logic              tx_n;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    logic              empty;
    logic              full;
    logic              busy;
    logic              push;
    logic              pop;
    logic              baud_last;
    logic [7:0]        head;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign busy      = (state != IDLE);
    assign push      = we && !full;
    assign head      = mem[rd_ptr] & DATA_MASK;
    assign baud_last = (baud == BAUD_W'(DIV - 1));

    assign status = {16'd0, 8'(count), 4'd0, overflow, busy, full, empty};

    // Storage needs no reset; stale entries are never read while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Full is judged before any pop, so a write into a full FIFO is dropped
    // even when the transmitter frees a slot in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (we && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            par_bit <= par_bit_n;
            uart_tx <= tx_n;
        end
    end

    // bit_idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        par_bit_n = par_bit;
        pop       = 1'b0;

        if (state != IDLE) begin
            baud_n = baud_last ? '0 : baud + 1'b1;
        end

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    baud_n  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shift_n   = shift >> 1;
                    end
                end
            end
            PAR: begin
                if (baud_last) begin
                    state_n   = STOP;
                    bit_idx_n = '0;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (pop) begin
            shift_n   = head;
            par_bit_n = (^head) ^ (PARITY == 2);
        end
    end

    // The line level is decoded from next-state values so uart_tx is a flop.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PAR:     tx_n = par_bit_n;
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a serial receiver monitor checks frames
// against expectations queued by the stimulus, plus directed status checks.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_a = 1'b0;
    logic        we_b = 1'b0;
    logic        we_c = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [31:0] status_a;
    logic [31:0] status_b;
    logic [31:0] status_c;
    logic        tx_a;
    logic        tx_b;
    logic        tx_c;
    logic        mon_line;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int sel = 0;
    int m_data_bits = 8;
    int m_parity = 0;
    int m_stop_bits = 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start_at;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we_a), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .status(status_a), .uart_tx(tx_a)
    );

    uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .we(we_b), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .status(status_b), .uart_tx(tx_b)
    );

    uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .we(we_c), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .status(status_c), .uart_tx(tx_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mon_line = (sel == 0) ? tx_a : ((sel == 1) ? tx_b : tx_c);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one store strobe for one clock; queues the frame it should produce.
    task automatic applyStimulus(input int which, input logic [7:0] d, input logic [7:0] exp_data,
                                 input logic sent, input logic par, input int start_at);
        exp_t e;
        wr_data = d;
        case (which)
            0:       we_a = 1'b1;
            1:       we_b = 1'b1;
            default: we_c = 1'b1;
        endcase
        if (sent) begin
            e.data     = exp_data;
            e.par      = par;
            e.start_at = start_at;
            exp_q.push_back(e);
        end
        @(negedge clk);
        we_a = 1'b0;
        we_b = 1'b0;
        we_c = 1'b0;
    endtask

    task automatic gotoCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || status_a[2] || status_b[2] || status_c[2]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_in_time", 32'(n < budget), 32'd1);
    endtask

    // Receiver: samples each bit mid-period, abandons a frame cut by reset.
    initial begin : monitor
        logic [15:0] bits;
        logic [7:0]  rxd;
        int          nbits;
        int          start_cyc;
        bit          aborted;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && mon_line === 1'b0) begin
                start_cyc = cyc;
                nbits = 1 + m_data_bits + ((m_parity != 0) ? 1 : 0) + m_stop_bits;
                aborted = 1'b0;
                bits = '0;
                for (int b = 0; b < nbits; b++) begin
                    repeat ((b == 0) ? DIV / 2 : DIV) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    bits[b] = mon_line;
                end
                if (!aborted) begin
                    rxd = '0;
                    for (int i = 0; i < m_data_bits; i++) rxd[i] = bits[1 + i];
                    checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("start_bit", {31'd0, bits[0]}, 32'd0);
                        checkOutput("rx_data", {24'd0, rxd}, {24'd0, e.data});
                        if (m_parity != 0) begin
                            checkOutput("parity_bit", {31'd0, bits[1 + m_data_bits]}, {31'd0, e.par});
                        end
                        for (int s = 0; s < m_stop_bits; s++) begin
                            checkOutput("stop_bit", {31'd0, bits[nbits - m_stop_bits + s]}, 32'd1);
                        end
                        checkOutput("frame_start_cycle", start_cyc, e.start_at);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int base;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_status_a", status_a, 32'h0000_0001);
        checkOutput("reset_tx_a", {31'd0, tx_a}, 32'd1);
        checkOutput("reset_status_b", status_b, 32'h0000_0001);
        checkOutput("reset_tx_c", {31'd0, tx_c}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single 8N1 frame of 0x55; cycle k is observed at cyc base+1+k.
        base = cyc;
        applyStimulus(0, 8'h55, 8'h55, 1'b1, 1'b0, base + 2);
        checkOutput("single_status_c0", status_a, 32'h0000_0100);
        checkOutput("single_tx_c0", {31'd0, tx_a}, 32'd1);
        @(negedge clk);
        checkOutput("single_tx_c1", {31'd0, tx_a}, 32'd0);
        checkOutput("single_status_c1", status_a, 32'h0000_0005);
        gotoCycle(base + 1 + 4);
        checkOutput("single_tx_c4", {31'd0, tx_a}, 32'd0);
        gotoCycle(base + 1 + 5);
        checkOutput("single_tx_c5", {31'd0, tx_a}, 32'd1);
        gotoCycle(base + 1 + 36);
        checkOutput("single_tx_c36", {31'd0, tx_a}, 32'd0);
        gotoCycle(base + 1 + 37);
        checkOutput("single_tx_c37", {31'd0, tx_a}, 32'd1);
        gotoCycle(base + 1 + 40);
        checkOutput("single_busy_c40", status_a, 32'h0000_0005);
        gotoCycle(base + 1 + 41);
        checkOutput("single_idle_c41", status_a, 32'h0000_0001);
        waitDrain(100);

        // Back-to-back pushes on consecutive cycles.
        base = cyc;
        applyStimulus(0, 8'hA1, 8'hA1, 1'b1, 1'b0, base + 2);
        checkOutput("b2b_count_e0", {24'd0, status_a[15:8]}, 32'd1);
        applyStimulus(0, 8'h3C, 8'h3C, 1'b1, 1'b0, base + 42);
        checkOutput("b2b_count_e1", {24'd0, status_a[15:8]}, 32'd1);
        applyStimulus(0, 8'hFF, 8'hFF, 1'b1, 1'b0, base + 82);
        checkOutput("b2b_count_peak", {24'd0, status_a[15:8]}, 32'd2);
        gotoCycle(base + 81);
        checkOutput("b2b_not_empty", {31'd0, status_a[0]}, 32'd0);
        gotoCycle(base + 82);
        checkOutput("b2b_empty_frame3", {31'd0, status_a[0]}, 32'd1);
        waitDrain(200);

        // Overflow: six pushes while the first frame is on the line.
        base = cyc;
        applyStimulus(0, 8'h11, 8'h11, 1'b1, 1'b0, base + 2);
        applyStimulus(0, 8'h22, 8'h22, 1'b1, 1'b0, base + 42);
        applyStimulus(0, 8'h33, 8'h33, 1'b1, 1'b0, base + 82);
        applyStimulus(0, 8'h44, 8'h44, 1'b1, 1'b0, base + 122);
        applyStimulus(0, 8'h5A, 8'h5A, 1'b1, 1'b0, base + 162);
        applyStimulus(0, 8'h66, 8'h00, 1'b0, 1'b0, 0);
        checkOutput("ovf_status_full", status_a, 32'h0000_040E);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", status_a, 32'h0000_0406);

        // Write at full on the cycle STOP ends, with a clear that must lose.
        gotoCycle(base + 41);
        checkOutput("ovf_full_before_pop", status_a, 32'h0000_0406);
        wr_data = 8'h77;
        we_a = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
        ovf_clr = 1'b0;
        checkOutput("ovf_push_pop_at_full", status_a, 32'h0000_030C);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        waitDrain(300);
        checkOutput("ovf_drained_status", status_a, 32'h0000_0001);

        // Even parity, 7 data bits, 2 stop bits.
        sel = 1;
        m_data_bits = 7;
        m_parity = 1;
        m_stop_bits = 2;
        base = cyc;
        applyStimulus(1, 8'h07, 8'h07, 1'b1, 1'b1, base + 2);
        gotoCycle(base + 1 + 32);
        checkOutput("par7_tx_d6", {31'd0, tx_b}, 32'd0);
        gotoCycle(base + 1 + 36);
        checkOutput("par7_tx_parity", {31'd0, tx_b}, 32'd1);
        gotoCycle(base + 1 + 44);
        checkOutput("par7_busy_c44", {31'd0, status_b[2]}, 32'd1);
        checkOutput("par7_tx_stop2", {31'd0, tx_b}, 32'd1);
        gotoCycle(base + 1 + 45);
        checkOutput("par7_idle_c45", {31'd0, status_b[2]}, 32'd0);
        base = cyc;
        applyStimulus(1, 8'h85, 8'h05, 1'b1, 1'b0, base + 2);
        waitDrain(100);

        // Odd parity, 8 data bits.
        sel = 2;
        m_data_bits = 8;
        m_parity = 2;
        m_stop_bits = 1;
        base = cyc;
        applyStimulus(2, 8'h07, 8'h07, 1'b1, 1'b0, base + 2);
        applyStimulus(2, 8'h03, 8'h03, 1'b1, 1'b1, base + 46);
        waitDrain(150);

        // Reset in the middle of a data phase with two bytes queued.
        sel = 0;
        m_data_bits = 8;
        m_parity = 0;
        m_stop_bits = 1;
        base = cyc;
        applyStimulus(0, 8'hC3, 8'h00, 1'b0, 1'b0, 0);
        applyStimulus(0, 8'h96, 8'h00, 1'b0, 1'b0, 0);
        applyStimulus(0, 8'hE7, 8'h00, 1'b0, 1'b0, 0);
        gotoCycle(base + 1 + 12);
        checkOutput("rst_pre_status", status_a, 32'h0000_0204);
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_immediate", {31'd0, tx_a}, 32'd1);
        checkOutput("rst_status_immediate", status_a, 32'h0000_0001);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            checkOutput("post_rst_tx", {31'd0, tx_a}, 32'd1);
            checkOutput("post_rst_status", status_a, 32'h0000_0001);
        end

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
